// File: rtl/rng_sched_pkg.sv
// Shared types and constants for the LFSR request scheduler.
// Optional statistics are enabled with RNG_SCHED_STATS_EN (see rng_scheduler).
package rng_sched_pkg;

  typedef enum logic [2:0] {
    ST_UNSEEDED,
    ST_SEED,
    ST_IDLE,
    ST_MODE,
    ST_SAMPLE,
    ST_RESP
  } state_t;

  localparam logic [1:0] MODE_FULL = 2'd0;
  localparam logic [1:0] MODE_INT  = 2'd1;
  localparam logic [1:0] MODE_NZ   = 2'd2;

  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly above ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic hit;

  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    any = |req;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (int'(ptr) + 1 + k) % N;
      if (!hit && req[c]) begin
        hit    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/rng_scheduler.sv
// Shares one LFSR among NUM_REQ requesters: seeding, round-robin grant, mode, post-processing.
// Define RNG_SCHED_STATS_EN to add saturating grant/resample counters.
module rng_scheduler #(
  parameter int S_WIDTH   = 8,
  parameter int INT_WIDTH = 2,
  parameter int NUM_REQ   = 4,
  parameter logic [S_WIDTH-1:0] DEFAULT_SEED = S_WIDTH'(rng_sched_pkg::DEFAULT_SEED)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   seed_load_i,
  input  logic [S_WIDTH-1:0]     seed_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [2*NUM_REQ-1:0]   req_mode_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  output logic [S_WIDTH-1:0]     rsp_data_o,
  output logic                   ready_o,
  output logic                   rng_seed_valid_o,
  output logic [S_WIDTH-1:0]     rng_seed_o,
  output logic [1:0]             rng_mode_o,
  input  logic [S_WIDTH-1:0]     rng_num_i,
  input  logic [INT_WIDTH-1:0]   rng_int_i
`ifdef RNG_SCHED_STATS_EN
  ,
  output logic [15:0]            stat_grants_o,
  output logic [15:0]            stat_resample_o
`endif
);

  import rng_sched_pkg::*;

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state_reg;
  logic [IW-1:0]        ptr_reg;
  logic [IW-1:0]        idx_reg;
  logic [1:0]           mode_reg;
  logic                 pend_reg;
  logic [S_WIDTH-1:0]   seed_cap_reg;
  logic [S_WIDTH-1:0]   seed_reg;
  logic [S_WIDTH-1:0]   rsp_data_reg;
  logic [NUM_REQ-1:0]   rsp_valid_reg;
  logic                 ready_reg;
  logic                 seed_valid_reg;
  logic [1:0]           rng_mode_reg;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic [1:0]           req_mode_sel;
  logic                 grant_ok;
  logic                 seed_start;
  logic                 resample;
  logic [S_WIDTH-1:0]   seed_src;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req (req_i),
    .ptr (ptr_reg),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Seed loads win over requests in IDLE, so the grant is qualified by seed_load_i.
  assign grant_ok     = (state_reg == ST_IDLE) && !seed_load_i && arb_any;
  assign gnt_o        = grant_ok ? arb_gnt : '0;
  assign req_mode_sel = req_mode_i[2*int'(arb_idx) +: 2];
  assign seed_start   = ((state_reg == ST_UNSEEDED || state_reg == ST_IDLE) && seed_load_i) ||
                        ((state_reg == ST_RESP) && (pend_reg || seed_load_i));
  assign seed_src     = seed_load_i ? seed_i : seed_cap_reg;
  assign resample     = (state_reg == ST_SAMPLE) && (mode_reg == MODE_NZ) && (rng_num_i == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= ST_UNSEEDED;
      ptr_reg        <= IW'(NUM_REQ - 1);
      idx_reg        <= '0;
      mode_reg       <= MODE_FULL;
      pend_reg       <= 1'b0;
      seed_cap_reg   <= '0;
      seed_reg       <= '0;
      rsp_data_reg   <= '0;
      rsp_valid_reg  <= '0;
      ready_reg      <= 1'b0;
      seed_valid_reg <= 1'b0;
      rng_mode_reg   <= 2'b00;
    end else begin
      rsp_valid_reg  <= '0;
      seed_valid_reg <= 1'b0;
      if (seed_start) begin
        seed_reg       <= (seed_src == '0) ? DEFAULT_SEED : seed_src;
        seed_valid_reg <= 1'b1;
        pend_reg       <= 1'b0;
      end
      case (state_reg)
        ST_UNSEEDED: if (seed_start) state_reg <= ST_SEED;
        ST_SEED: begin
          ready_reg <= 1'b1;
          state_reg <= ST_IDLE;
        end
        ST_IDLE: begin
          if (seed_start) begin
            state_reg <= ST_SEED;
          end else if (grant_ok) begin
            ptr_reg      <= arb_idx;
            idx_reg      <= arb_idx;
            mode_reg     <= (req_mode_sel == 2'd3) ? MODE_FULL : req_mode_sel;
            rng_mode_reg <= (req_mode_sel == MODE_INT) ? 2'b01 : 2'b00;
            state_reg    <= ST_MODE;
          end
        end
        ST_MODE: begin
          if (seed_load_i) begin
            pend_reg     <= 1'b1;
            seed_cap_reg <= seed_i;
          end
          state_reg <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (seed_load_i) begin
            pend_reg     <= 1'b1;
            seed_cap_reg <= seed_i;
          end
          if (!resample) begin
            rsp_valid_reg <= NUM_REQ'(1) << idx_reg;
            rsp_data_reg  <= (mode_reg == MODE_INT) ? S_WIDTH'(rng_int_i) : rng_num_i;
            state_reg     <= ST_RESP;
          end
        end
        ST_RESP: begin
          rng_mode_reg <= 2'b00;
          state_reg    <= seed_start ? ST_SEED : ST_IDLE;
        end
        default: state_reg <= ST_UNSEEDED;
      endcase
    end
  end

  assign rsp_valid_o      = rsp_valid_reg;
  assign rsp_data_o       = rsp_data_reg;
  assign ready_o          = ready_reg;
  assign rng_seed_valid_o = seed_valid_reg;
  assign rng_seed_o       = seed_reg;
  assign rng_mode_o       = rng_mode_reg;

`ifdef RNG_SCHED_STATS_EN
  logic [15:0] grants_reg;
  logic [15:0] resample_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i || seed_start) begin
      grants_reg   <= '0;
      resample_reg <= '0;
    end else begin
      if (grant_ok && grants_reg != 16'hFFFF) grants_reg <= grants_reg + 16'd1;
      if (resample && resample_reg != 16'hFFFF) resample_reg <= resample_reg + 16'd1;
    end
  end

  assign stat_grants_o   = grants_reg;
  assign stat_resample_o = resample_reg;
`endif

endmodule

// File: tb/tb_rng_scheduler.sv
// Self-checking bench for rng_scheduler: directed table, hand sequences, randomized model run.
module tb_rng_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       seed_load;
  logic [7:0] seed;
  logic [3:0] req;
  logic [7:0] req_mode;
  logic [3:0] gnt;
  logic [3:0] rsp_valid;
  logic [7:0] rsp_data;
  logic       ready;
  logic       seed_valid;
  logic [7:0] seed_out;
  logic [1:0] rmode;
  logic [7:0] num;
  logic [1:0] ival;
`ifdef RNG_SCHED_STATS_EN
  logic [15:0] stat_grants;
  logic [15:0] stat_resample;
`endif

  rng_scheduler #(.S_WIDTH(8), .INT_WIDTH(2), .NUM_REQ(4), .DEFAULT_SEED(8'hA5)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .seed_load_i      (seed_load),
    .seed_i           (seed),
    .req_i            (req),
    .req_mode_i       (req_mode),
    .gnt_o            (gnt),
    .rsp_valid_o      (rsp_valid),
    .rsp_data_o       (rsp_data),
    .ready_o          (ready),
    .rng_seed_valid_o (seed_valid),
    .rng_seed_o       (seed_out),
    .rng_mode_o       (rmode),
    .rng_num_i        (num),
    .rng_int_i        (ival)
`ifdef RNG_SCHED_STATS_EN
    ,
    .stat_grants_o    (stat_grants),
    .stat_resample_o  (stat_resample)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Directed table: one row per cycle, outputs checked after inputs settle.
  typedef struct {
    logic       sl;
    logic [7:0] sd;
    logic [3:0] r;
    logic [7:0] n;
    logic [3:0] e_gnt;
    logic       e_rdy;
    logic       e_sv;
    logic [7:0] e_sd;
    logic [3:0] e_rv;
    logic [7:0] e_rd;
  } vec_t;

  vec_t tbl[13];

  // Reference model state: transactions tracked by cycle numbers.
  int         t = 0;
  int         m_ptr = 1;
  bit         m_busy = 0;
  bit         m_cap = 0;
  bit         m_pend = 0;
  int         m_idx = 0;
  int         m_mode = 0;
  int         m_g = -10;
  int         m_rsp = -1;
  int         m_seed_cyc = -1;
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_rd = 8'h00;
  logic [7:0] m_seed_next = 8'hA5;
  logic [7:0] m_seed_shown = 8'hA5;
  logic [3:0] m_last_gnt = 4'h0;
  int         g_seen = -100;
  int         r_seen = -100;

  task automatic step(input logic sl, input logic [7:0] sd, input logic [3:0] r,
                      input logic [7:0] modes, input logic [7:0] n, input logic [1:0] iv);
    logic [3:0] eg;
    logic [3:0] erv;
    logic [1:0] emode;
    int         pick;
    int         em;
    bit         busy_now;
    seed_load = sl; seed = sd; req = r; req_mode = modes; num = n; ival = iv;
    #1;
    busy_now = m_busy;
    pick = -1;
    eg = 4'h0;
    if (!m_busy && t != m_seed_cyc && !sl) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (pick < 0 && r[c]) pick = c;
      end
    end
    if (pick >= 0) eg[pick] = 1'b1;
    erv = 4'h0;
    if (m_busy && m_cap && t == m_rsp) begin
      erv[m_idx] = 1'b1;
      m_rd = m_data;
    end
    emode = (m_busy && t > m_g && m_mode == 1) ? 2'b01 : 2'b00;
    if (t == m_seed_cyc) m_seed_shown = m_seed_next;

    check("gnt", gnt, eg);
    check("rsp_valid", rsp_valid, erv);
    check("rsp_data", rsp_data, m_rd);
    check("ready", ready, 1);
    check("seed_valid", seed_valid, (t == m_seed_cyc) ? 1 : 0);
    check("seed", seed_out, m_seed_shown);
    check("rng_mode", rmode, emode);
    $display("cyc %0d req=%b gnt=%b rsp_valid=%b data=%02h mode=%b", t, r, gnt, rsp_valid, rsp_data, rmode);
    if (gnt != 0) g_seen = t;
    if (rsp_valid != 0) r_seen = t;

    // Capture happens from the second cycle after grant; mode 2 skips zeros.
    if (m_busy && !m_cap && t >= m_g + 2) begin
      if (!(m_mode == 2 && n == 8'h00)) begin
        m_cap  = 1;
        m_data = (m_mode == 1) ? {6'd0, iv} : n;
        m_rsp  = t + 1;
      end
    end
    if (busy_now && m_cap && t == m_rsp) begin
      m_busy = 0;
      if (m_pend || sl) begin
        m_pend = 0;
        m_seed_cyc = t + 1;
      end
    end else if (sl && busy_now) begin
      m_pend = 1;
    end else if (sl) begin
      m_seed_cyc = t + 1;
    end
    if (sl) m_seed_next = (sd == 8'h00) ? 8'hA5 : sd;
    if (pick >= 0) begin
      m_busy = 1;
      m_cap  = 0;
      m_g    = t;
      m_idx  = pick;
      em     = int'(modes[2*pick +: 2]);
      m_mode = (em == 3) ? 0 : em;
      m_ptr  = pick;
    end
    m_last_gnt = eg;
    t++;
    @(posedge clk);
    #1;
  endtask

  bit         want[4];
  logic [1:0] wmode[4];

  initial begin
    logic [3:0] rr;
    logic [7:0] mm;
    logic       sl;
    logic [7:0] sd;
    logic [7:0] nn;

    rst = 1'b1; seed_load = 1'b0; seed = 8'h00; req = 4'h0; req_mode = 8'h00; num = 8'h00; ival = 2'd0;
    //           sl  sd     r     n      gnt   rdy sv  sd     rv    rd
    tbl[0]  = '{1'b0, 8'h00, 4'h1, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00};
    tbl[1]  = '{1'b1, 8'h5A, 4'h1, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00};
    tbl[2]  = '{1'b0, 8'h00, 4'h1, 8'h00, 4'h0, 1'b0, 1'b1, 8'h5A, 4'h0, 8'h00};
    tbl[3]  = '{1'b0, 8'h00, 4'h1, 8'h00, 4'h1, 1'b1, 1'b0, 8'h5A, 4'h0, 8'h00};
    tbl[4]  = '{1'b0, 8'h00, 4'h0, 8'h11, 4'h0, 1'b1, 1'b0, 8'h5A, 4'h0, 8'h00};
    tbl[5]  = '{1'b0, 8'h00, 4'h0, 8'h22, 4'h0, 1'b1, 1'b0, 8'h5A, 4'h0, 8'h00};
    tbl[6]  = '{1'b0, 8'h00, 4'h0, 8'h33, 4'h0, 1'b1, 1'b0, 8'h5A, 4'h1, 8'h22};
    tbl[7]  = '{1'b1, 8'h00, 4'h2, 8'h00, 4'h0, 1'b1, 1'b0, 8'h5A, 4'h0, 8'h22};
    tbl[8]  = '{1'b0, 8'h00, 4'h2, 8'h00, 4'h0, 1'b1, 1'b1, 8'hA5, 4'h0, 8'h22};
    tbl[9]  = '{1'b0, 8'h00, 4'h2, 8'h00, 4'h2, 1'b1, 1'b0, 8'hA5, 4'h0, 8'h22};
    tbl[10] = '{1'b0, 8'h00, 4'h0, 8'h44, 4'h0, 1'b1, 1'b0, 8'hA5, 4'h0, 8'h22};
    tbl[11] = '{1'b0, 8'h00, 4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 8'hA5, 4'h0, 8'h22};
    tbl[12] = '{1'b0, 8'h00, 4'h0, 8'h55, 4'h0, 1'b1, 1'b0, 8'hA5, 4'h2, 8'h00};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      seed_load = tbl[i].sl; seed = tbl[i].sd; req = tbl[i].r; num = tbl[i].n;
      #1;
      check("tbl_gnt", gnt, tbl[i].e_gnt);
      check("tbl_ready", ready, tbl[i].e_rdy);
      check("tbl_seed_valid", seed_valid, tbl[i].e_sv);
      check("tbl_seed", seed_out, tbl[i].e_sd);
      check("tbl_rsp_valid", rsp_valid, tbl[i].e_rv);
      check("tbl_rsp_data", rsp_data, tbl[i].e_rd);
      check("tbl_mode", rmode, 0);
      $display("row %0d req=%b gnt=%b ready=%b sv=%b seed=%02h rv=%b rd=%02h",
               i, req, gnt, ready, seed_valid, seed_out, rsp_valid, rsp_data);
      @(posedge clk);
      #1;
    end

    // All four requesting, mode 0: 16 back-to-back responses.
    for (int i = 0; i < 64; i++)
      step(1'b0, 8'h00, 4'hF, 8'h00, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));

    // Mode 1 on requester 0: small integer, upper bits zero.
    for (int i = 0; i < 16; i++)
      step(1'b0, 8'h00, 4'h1, 8'h01, 8'($urandom_range(4, 255)), 2'($urandom_range(0, 3)));

    // Mode 2 on requester 2 with generator returning 0, 0, 8'h17.
    g_seen = -100; r_seen = -100;
    step(1'b0, 8'h00, 4'h4, 8'h20, 8'h00, 2'd0);
    step(1'b0, 8'h00, 4'h0, 8'h20, 8'h55, 2'd0);
    step(1'b0, 8'h00, 4'h0, 8'h20, 8'h00, 2'd0);
    step(1'b0, 8'h00, 4'h0, 8'h20, 8'h00, 2'd0);
    step(1'b0, 8'h00, 4'h0, 8'h20, 8'h17, 2'd0);
    step(1'b0, 8'h00, 4'h0, 8'h20, 8'h99, 2'd0);
    check("nz_latency", 32'(r_seen - g_seen), 5);
    check("nz_data", rsp_data, 8'h17);

    // Seed load during SAMPLE: response first, then SEED, then next grant.
    for (int i = 0; i < 8; i++)
      step((i == 2), 8'h3C, 4'h1, 8'h00, 8'($urandom_range(0, 255)), 2'd0);

    // Randomized traffic with occasional seed loads.
    for (int i = 0; i < 4; i++) begin want[i] = 0; wmode[i] = 2'd0; end
    for (int i = 0; i < 400; i++) begin
      rr = 4'h0; mm = 8'h00;
      for (int j = 0; j < 4; j++) begin
        if (!want[j] && $urandom_range(0, 3) == 0) begin
          want[j] = 1;
          wmode[j] = 2'($urandom_range(0, 3));
        end
        rr[j] = want[j];
        mm[2*j +: 2] = wmode[j];
      end
      sl = ($urandom_range(0, 39) == 0) && (t != m_seed_cyc);
      sd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      nn = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      step(sl, sd, rr, mm, nn, 2'($urandom_range(0, 3)));
      for (int j = 0; j < 4; j++)
        if (m_last_gnt[j]) want[j] = ($urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rng_scheduler.md
# rng_scheduler

Shares the single LFSR random-number generator among up to NUM_REQ requesters (mutation, crossover, selection units). Loads the seed, arbitrates round-robin, drives the generator's mode, and returns one post-processed random value per granted request. Sits between the GA operator units and the LFSR instance.

## Interface
- S_WIDTH, 8, random value width; must match the generator.
- INT_WIDTH, 2, small-integer width (mode 1).
- NUM_REQ, 4, number of requesters (2..8).
- DEFAULT_SEED, 8'hA5, substituted when a zero seed is loaded.

- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- seed_load_i  in  1  pulse; load seed_i into generator.
- seed_i  in  S_WIDTH  seed value.
- req_i  in  NUM_REQ  per-requester request level.
- req_mode_i  in  2*NUM_REQ  per-requester mode, 0: 0..255, 1: 0..2^INT_WIDTH-1, 2: 1..255; 3 is reserved and treated as 0.
- gnt_o  out  NUM_REQ  one-hot, 1-cycle accept pulse.
- rsp_valid_o  out  NUM_REQ  one-hot, 1-cycle result pulse.
- rsp_data_o  out  S_WIDTH  result, valid with rsp_valid_o.
- ready_o  out  1  generator seeded; requests are serviced.
- rng_seed_valid_o  out  1  to generator seed-valid.
- rng_seed_o  out  S_WIDTH  to generator seed.
- rng_mode_o  out  2  to generator mode.
- rng_num_i  in  S_WIDTH  generator full-width registered output.
- rng_int_i  in  INT_WIDTH  generator small-int registered output.

## Operation
- FSM states: UNSEEDED, SEED, IDLE, MODE, SAMPLE, RESP.
- UNSEEDED: after reset. Ignores req_i, ready_o=0. On seed_load_i, goes to SEED.
- SEED: one cycle. rng_seed_valid_o=1, rng_seed_o=seed_i captured at load, or DEFAULT_SEED if the captured seed is zero. Then goes to IDLE and ready_o=1 from that cycle on.
- IDLE: seed_load_i has priority over requests and goes to SEED. Otherwise, if any req_i is high, the round-robin arbiter picks the first requester above the last-granted index (wrapping). gnt_o pulses, the index and mode are latched, and the FSM goes to MODE.
- MODE: rng_mode_o is driven from the latched mode: 1 drives 2'b01, others drive 2'b00. It stays driven until RESP. Then goes to SAMPLE.
- SAMPLE: captures the value. Mode 0 takes rng_num_i. Mode 1 takes rng_int_i zero-extended. Mode 2 takes rng_num_i; if it is zero, the FSM stays in SAMPLE and resamples the next cycle. Then goes to RESP.
- RESP: rsp_valid_o[idx] pulses and rsp_data_o holds the value. Then goes to IDLE.
- seed_load_i arriving in MODE, SAMPLE or RESP sets a pending flag. The in-flight request completes, then SEED runs before the next grant.
- A requester keeps req_i high until gnt_o. After gnt_o it may drop or hold req_i. If req_i is still high in IDLE after RESP, that counts as a new request.
- The last-granted pointer resets to NUM_REQ-1, so requester 0 wins first.

## Timing
- Reset values: gnt_o=0, rsp_valid_o=0, rsp_data_o=0, ready_o=0, rng_seed_valid_o=0, rng_seed_o=0, rng_mode_o=0. Pointer=NUM_REQ-1, pending flag=0.
- Grant in cycle G, rng_mode_o is valid in G+1, sample at end of G+2, rsp_valid_o in G+3. Latency is 3 cycles plus one per mode-2 resample.
- Throughput: at most one response every 4 cycles. Back-to-back requests are served with no idle gap.
- The seed is applied 1 cycle after seed_load_i in IDLE or UNSEEDED.
- The generator's output is stale for 1 cycle after a mode change; the MODE state absorbs this.

## Configuration
- RNG_SCHED_STATS_EN defined: adds stat_grants_o (16 bit, total grants, saturating) and stat_resample_o (16 bit, total mode-2 resamples, saturating). Both are cleared by rst_i and by each seed load.
- RNG_SCHED_STATS_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package rng_sched_pkg holds:
  - the state enum;
  - mode constants MODE_FULL=0, MODE_INT=1, MODE_NZ=2;
  - the DEFAULT_SEED constant.
- Sub-module rr_arbiter: combinational round-robin pick from a request vector and pointer, returning a one-hot grant and an index.

## Test plan
- Reset, then req_i=4'b0001 without a seed: no gnt_o, ready_o=0. Then seed_load_i with seed 8'h5A: rng_seed_valid_o=1 with rng_seed_o=8'h5A one cycle later, then ready_o=1 and gnt_o=4'b0001.
- seed_i=0 loaded: rng_seed_o=8'hA5.
- req_i=4'b1111 held for 16 responses: grants go 0,1,2,3,0,… Each rsp_valid_o arrives exactly 3 cycles after its gnt_o and matches the index.
- Mode 1 request: rsp_data_o<=3 with upper bits zero. rng_mode_o=2'b01 is seen during MODE and SAMPLE.
- Mode 2 with a stubbed generator returning 0,0,8'h17: two resamples, rsp_data_o=8'h17, latency 5.
- seed_load_i during SAMPLE: the current response still delivers, then SEED occurs, and the next grant comes only after it.
